// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: result width helper,
// row index type and result-collector state encoding.
package systolic_pkg;

  localparam int unsigned DIM_DEFAULT     = 8;
  localparam int unsigned BITS_AB_DEFAULT = 8;

  // Width of an accumulated result: product width plus growth from DIM adds.
  function automatic int unsigned bits_c_calc(input int unsigned bits_ab,
                                              input int unsigned dim);
    return 2 * bits_ab + $clog2(dim);
  endfunction

  typedef logic [$clog2(DIM_DEFAULT)-1:0] row_idx_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/deskew_delay.sv
// En-qualified delay line of DEPTH stages; DEPTH 0 is a plain passthrough.
module deskew_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned BITS  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en, flush};
    assign q = d;
  end else begin : g_shift
    logic [BITS-1:0] sr [DEPTH];

    // Shift one stage per enabled cycle; flush zeroes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/memc_deskew.sv
// Output-side result collector: removes the anti-diagonal skew of the array
// outputs and captures DIM aligned rows into a flop buffer read by row.
module memc_deskew
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_C = bits_c_calc(BITS_AB_DEFAULT, DIM_DEFAULT),
  parameter int unsigned DIM    = DIM_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           en,
  input  logic signed [DIM*BITS_C-1:0]   Cin,
  input  logic        [DIM-1:0]          Cvalid,
  input  logic                           rd_en,
  input  logic        [$clog2(DIM)-1:0]  rd_row,
  output logic signed [DIM*BITS_C-1:0]   rd_data,
  output logic                           rd_valid,
  output logic                           full,
  output logic        [$clog2(DIM):0]    rows,
  output logic                           err
);

  localparam int unsigned RW    = $clog2(DIM);
  localparam logic [RW:0] DIM_L = (RW+1)'(DIM);

  // Aligned row from the delay lines
  logic [DIM-1:0]    dv;
  logic [BITS_C-1:0] dd [DIM];
  logic              row_valid;
  logic              partial;

  for (genvar c = 0; c < DIM; c++) begin : g_col
    logic [BITS_C:0] dq;

    deskew_delay #(
      .DEPTH (DIM - 1 - c),
      .BITS  (BITS_C + 1)
    ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .flush (clr),
      .d     ({Cvalid[c], Cin[c*BITS_C +: BITS_C]}),
      .q     (dq)
    );

    assign dv[c] = dq[BITS_C];
    assign dd[c] = dq[BITS_C-1:0];
  end

  assign row_valid = &dv;
  assign partial   = (|dv) && !row_valid;

  // Capture state
  state_t          state_q, state_d;
  logic   [RW:0]   rows_q, rows_d;
  logic            err_q, err_d;
  logic            full_q;
  logic            wr_en;
  logic   [RW-1:0] wr_row;

  logic [BITS_C-1:0] mem_q [DIM][DIM];

  assign wr_row = rows_q[RW-1:0];

  // Next-state: clr dominates, then partial rows, then capture / overflow.
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    if (clr) begin
      state_d = EMPTY;
      rows_d  = '0;
      err_d   = 1'b0;
    end else if (en) begin
      if (partial) begin
        err_d = 1'b1;
      end else if (row_valid) begin
        case (state_q)
          EMPTY, COLLECT: begin
            wr_en   = 1'b1;
            rows_d  = rows_q + (RW+1)'(1);
            state_d = (rows_d == DIM_L) ? FULL : COLLECT;
          end
          FULL:    err_d   = 1'b1;
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rows_q  <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      err_q   <= err_d;
      full_q  <= (state_d == FULL);
    end
  end

  // Result buffer: one aligned row written per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DIM; r++)
        for (int unsigned c = 0; c < DIM; c++)
          mem_q[r][c] <= '0;
    end else if (wr_en) begin
      for (int unsigned c = 0; c < DIM; c++)
        mem_q[wr_row][c] <= dd[c];
    end
  end

  // Registered read port; sees the buffer before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if ({1'b0, rd_row} < DIM_L) begin
          for (int unsigned c = 0; c < DIM; c++)
            rd_data[c*BITS_C +: BITS_C] <= mem_q[rd_row][c];
        end else begin
          rd_data <= '0;
        end
      end
    end
  end

  assign full = full_q;
  assign rows = rows_q;
  assign err  = err_q;

endmodule
